serial_mag_compare_ctrl: RTL

//  Sequencer that compares two WIDTH-bit unsigned operands over several cycles.
//  It uses a 2-bit magnitude compare slice (g/e/l on one bit-pair per cycle).

---
 rtl/serial_mag_compare_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/serial_mag_compare_ctrl.sv
// Multi-cycle unsigned magnitude comparator: walks operand bit-pairs MSB-first
// through a 2-bit compare slice and stops at the first unequal pair.
module serial_mag_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NPAIR = WIDTH / 2;
  localparam int IW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  logic [1:0]       pair_a, pair_b;
  logic             pair_gt, pair_lt, idx_zero;

  // 2-bit compare slice on the currently selected pair
  always_comb begin
    pair_a = '0;
    pair_b = '0;
    for (int unsigned p = 0; p < NPAIR; p++) begin
      if (idx_q == IW'(p)) begin
        pair_a = ra_q[2*p +: 2];
        pair_b = rb_q[2*p +: 2];
      end
    end
    pair_gt  = (pair_a > pair_b);
    pair_lt  = (pair_a < pair_b);
    idx_zero = (idx_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      idx_q   <= IW'(NPAIR - 1);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          idx_d   = IW'(NPAIR - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (pair_gt || pair_lt || idx_zero) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs: values computed here land in the flops on the same edge as the state change
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    gt_d   = gt_q;
    eq_d   = eq_q;
    lt_d   = lt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          gt_d   = 1'b0;
          eq_d   = 1'b0;
          lt_d   = 1'b0;
        end
      end
      RUN: begin
        if (!abort) begin
          if (pair_gt) begin
            gt_d   = 1'b1;
            done_d = 1'b1;
          end else if (pair_lt) begin
            lt_d   = 1'b1;
            done_d = 1'b1;
          end else if (idx_zero) begin
            eq_d   = 1'b1;
            done_d = 1'b1;
          end else begin
            busy_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign gt   = gt_q;
  assign eq   = eq_q;
  assign lt   = lt_q;

endmodule
